// File: rtl/clock_pkg.sv
// clock_pkg: shared constants and types for the clock display path.
package clock_pkg;
    localparam int NUM_DIGITS = 6;
    typedef logic [2:0] dig_t;
    localparam logic [6:0] SEG_DASH = 7'h40;
    // gfedcba codes indexed by nibble; 10..15 render as a dash
    localparam logic [15:0][6:0] SEG_TABLE = {
        SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH,
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };
endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: combinational BCD nibble to seven-segment (gfedcba) decoder.
module bcd_to_seg7
    import clock_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);
    assign seg = SEG_TABLE[nib];
endmodule

// File: rtl/clock_display_scan.sv
// clock_display_scan: multiplexed 6-digit seven-segment scanner for BCD hh:mm:ss,
// snapshotting the time once per frame so a frame never mixes two seconds.
module clock_display_scan
    import clock_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int COMMON_ANODE = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ena,
    input  logic [7:0] hh,
    input  logic [7:0] mm,
    input  logic [7:0] ss,
    input  logic       blank_lz,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_done
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRE_TC = PW'(SCAN_DIV - 1);
    localparam dig_t LAST = dig_t'(NUM_DIGITS - 1);
    localparam logic INV = COMMON_ANODE != 0;

    logic [PW-1:0] pre_q, pre_d;
    dig_t          dig_q, dig_d;
    logic [23:0]   snap_q, snap_d, snap_sh;
    logic [5:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d, seg_raw;
    logic          dp_q, dp_d, fd_q, fd_d;
    logic          tc, blank;
    logic [3:0]    nib;

    bcd_to_seg7 u_dec (
        .nib(nib),
        .seg(seg_raw)
    );

    // Decode from snap_d so digit 0 already shows the snapshot taken on this edge
    always_comb begin
        tc = pre_q == PRE_TC;
        pre_d = (!ena || tc) ? '0 : pre_q + 1'b1;
        dig_d = !ena ? '0 : tc ? (dig_q == LAST ? '0 : dig_q + 1'b1) : dig_q;
        snap_d = (ena && dig_q == '0 && pre_q == '0) ? {hh, mm, ss} : snap_q;
        snap_sh = snap_d >> {dig_q, 2'b00};
        nib = snap_sh[3:0];
        blank = blank_lz && dig_q == LAST && snap_d[23:20] == 4'd0;
        an_d = {6{INV}} ^ ((ena && !blank) ? 6'd1 << dig_q : 6'd0);
        seg_d = {7{INV}} ^ ((ena && !blank) ? seg_raw : 7'd0);
        dp_d = INV ^ (ena && (dig_q == 3'd2 || dig_q == 3'd4));
        fd_d = ena && tc && dig_q == LAST;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q  <= '0;
            dig_q  <= '0;
            snap_q <= '0;
            an_q   <= {6{INV}};
            seg_q  <= {7{INV}};
            dp_q   <= INV;
            fd_q   <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            dig_q  <= dig_d;
            snap_q <= snap_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
            fd_q   <= fd_d;
        end
    end

    assign an = an_q;
    assign seg = seg_q;
    assign dp = dp_q;
    assign frame_done = fd_q;
endmodule

// File: tb/tb_clock_display_scan.sv
// tb_clock_display_scan: scoreboard bench driving both display polarities from one stimulus stream.
module tb_clock_display_scan;
    localparam int SD = 4;

    logic       clk = 1'b0, reset = 1'b0, ena = 1'b0, blank_lz = 1'b0;
    logic [7:0] hh = '0, mm = '0, ss = '0;
    logic [5:0] an0, an1;
    logic [6:0] seg0, seg1;
    logic       dp0, dp1, fd0, fd1;
    int         n_chk = 0, n_fail = 0, cyc = 0;

    typedef struct {
        int          cyc;
        logic [14:0] v;
        int          id;
    } exp_t;
    exp_t q[$];

    clock_display_scan #(.SCAN_DIV(SD), .COMMON_ANODE(0)) dut0 (
        .clk(clk), .reset(reset), .ena(ena), .hh(hh), .mm(mm), .ss(ss), .blank_lz(blank_lz),
        .an(an0), .seg(seg0), .dp(dp0), .frame_done(fd0)
    );
    clock_display_scan #(.SCAN_DIV(SD), .COMMON_ANODE(1)) dut1 (
        .clk(clk), .reset(reset), .ena(ena), .hh(hh), .mm(mm), .ss(ss), .blank_lz(blank_lz),
        .an(an1), .seg(seg1), .dp(dp1), .frame_done(fd1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [14:0] inv(input logic [14:0] v);
        return {~v[14:1], v[0]};
    endfunction

    task automatic chk(input string name, input int id, input logic [14:0] act, input logic [14:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s id=%0d got an=%h seg=%h dp=%b fd=%b want an=%h seg=%h dp=%b fd=%b",
                     name, id, act[14:9], act[8:2], act[1], act[0], exp[14:9], exp[8:2], exp[1], exp[0]);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            chk("dut0", e.id, {an0, seg0, dp0, fd0}, e.v);
            chk("dut1", e.id, {an1, seg1, dp1, fd1}, inv(e.v));
        end
    end

    task automatic push(input int id, input logic [14:0] v);
        exp_t e;
        e.cyc = cyc + 1;
        e.v = v;
        e.id = id;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input int id, input logic [41:0] s, input bit blank, input int chg,
                         input logic [7:0] nss, input int n);
        int d;
        logic b;
        logic [5:0] a;
        for (int i = 0; i < n; i++) begin
            d = i / SD;
            b = blank && d == 5;
            a = b ? 6'd0 : 6'd1 << d;
            push(id * 100 + i, {a, b ? 7'd0 : s[d*7 +: 7], !b && (d == 2 || d == 4), i == 6 * SD - 1});
            if (i == chg) ss = nss;
            step();
        end
    endtask

    task automatic idle(input int id, input int n);
        for (int i = 0; i < n; i++) begin
            push(id * 100 + i, 15'd0);
            step();
        end
    endtask

    task automatic chk_reset(input int id);
        chk("rst0", id, {an0, seg0, dp0, fd0}, 15'd0);
        chk("rst1", id, {an1, seg1, dp1, fd1}, inv(15'd0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        #3 reset = 1'b1;
        #1 chk_reset(0);
        step();
        hh = 8'h23; mm = 8'h59; ss = 8'h58; ena = 1'b1;
        reset = 1'b0;
        frame(1, {7'h5B, 7'h4F, 7'h6D, 7'h6F, 7'h6D, 7'h7F}, 0, -1, 8'h00, 24);
        frame(2, {7'h5B, 7'h4F, 7'h6D, 7'h6F, 7'h6D, 7'h7F}, 0, 12, 8'h59, 24);
        frame(3, {7'h5B, 7'h4F, 7'h6D, 7'h6F, 7'h6D, 7'h6F}, 0, -1, 8'h00, 10);
        @(negedge clk);
        #1 reset = 1'b1;
        #1 chk_reset(4);
        hh = 8'h07; mm = 8'h59; ss = 8'h59; blank_lz = 1'b1;
        step();
        step();
        reset = 1'b0;
        frame(5, {7'h3F, 7'h07, 7'h6D, 7'h6F, 7'h6D, 7'h6F}, 1, -1, 8'h00, 24);
        blank_lz = 1'b0;
        frame(6, {7'h3F, 7'h07, 7'h6D, 7'h6F, 7'h6D, 7'h6F}, 0, -1, 8'h00, 24);
        hh = 8'h23; ss = 8'h5A;
        frame(7, {7'h5B, 7'h4F, 7'h6D, 7'h6F, 7'h6D, 7'h40}, 0, -1, 8'h00, 24);
        frame(8, {7'h5B, 7'h4F, 7'h6D, 7'h6F, 7'h6D, 7'h40}, 0, -1, 8'h00, 10);
        ena = 1'b0;
        idle(9, 3);
        ss = 8'h47;
        ena = 1'b1;
        frame(10, {7'h5B, 7'h4F, 7'h6D, 7'h6F, 7'h66, 7'h07}, 0, -1, 8'h00, 24);
        ena = 1'b0;
        idle(11, 2);
        step();
        step();
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
